// File: rtl/fwd_pkg.sv
// fwd_pkg: shared types and helpers for the EX-stage bypass network.
// Tag rd is stored zero-extended to FWD_RD_W, so REG_AW must not exceed it.
package fwd_pkg;

    localparam int FWD_RD_W   = 8;
    localparam int FWD_SEL_RF = 0;

    typedef struct packed {
        logic                valid;
        logic [FWD_RD_W-1:0] rd;
        logic                regwrite;
        logic                memread;
    } fwd_tag_t;

    localparam int TAG_W = $bits(fwd_tag_t);

    function automatic logic tag_match(
        input fwd_tag_t            t,
        input logic [FWD_RD_W-1:0] addr
    );
        return t.valid && t.regwrite && (t.rd != '0) && (t.rd == addr);
    endfunction

endpackage

// File: rtl/fwd_sel_mux.sv
// fwd_sel_mux: youngest-first producer compare and operand mux
// for a single EX source operand.
module fwd_sel_mux
    import fwd_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2,
    parameter int SEL_W  = 2
) (
    input  logic [DEPTH*TAG_W-1:0]  tags_i,
    input  logic [FWD_RD_W-1:0]     src_addr_i,
    input  logic [DATA_W-1:0]       rf_data_i,
    input  logic [DEPTH*DATA_W-1:0] stage_data_i,
    output logic [DATA_W-1:0]       operand_o,
    output logic [SEL_W-1:0]        sel_o,
    output logic                    hit0_o
);

    // memread is only consumed by the top-level hazard logic
    logic tags_unused;
    assign tags_unused = ^tags_i;

    always_comb begin
        sel_o     = SEL_W'(FWD_SEL_RF);
        operand_o = rf_data_i;
        hit0_o    = 1'b0;
        // walk oldest to youngest so the lowest matching stage wins
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (tag_match(fwd_tag_t'(tags_i[k*TAG_W +: TAG_W]),
                          src_addr_i)) begin
                sel_o     = SEL_W'(k + 1);
                operand_o = stage_data_i[k*DATA_W +: DATA_W];
            end
        end
        hit0_o = tag_match(fwd_tag_t'(tags_i[TAG_W-1:0]), src_addr_i);
    end

endmodule

// File: rtl/fwd_bypass_unit.sv
// fwd_bypass_unit: EX operand bypass with internal producer tag pipeline
// and load-use bubble insertion. FWD_PERF_EN adds perf counters.
module fwd_bypass_unit
    import fwd_pkg::*;
#(
    parameter  int DATA_W  = 32,
    parameter  int REG_AW  = 5,
    parameter  int NUM_SRC = 2,
    parameter  int DEPTH   = 2,
    localparam int SEL_W   = $clog2(DEPTH + 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      stall_i,
    input  logic                      flush_i,
    input  logic                      ex_valid_i,
    input  logic [REG_AW-1:0]         ex_rd_i,
    input  logic                      ex_regwrite_i,
    input  logic                      ex_memread_i,
    input  logic [NUM_SRC*REG_AW-1:0] src_addr_i,
    input  logic [NUM_SRC*DATA_W-1:0] src_data_i,
    input  logic [DEPTH*DATA_W-1:0]   stage_data_i,
    output logic [NUM_SRC*DATA_W-1:0] operand_o,
    output logic [NUM_SRC*SEL_W-1:0]  fwd_sel_o,
`ifdef FWD_PERF_EN
    output logic [31:0]               fwd_cnt_o,
    output logic [31:0]               hazard_cnt_o,
`endif
    output logic                      hazard_o
);

    fwd_tag_t [DEPTH-1:0] tag_q;
    fwd_tag_t             tag_in;
    logic [NUM_SRC-1:0]   hit0;
    logic                 bubble;

    always_comb begin
        tag_in          = '0;
        tag_in.valid    = 1'b1;
        tag_in.rd       = FWD_RD_W'(ex_rd_i);
        tag_in.regwrite = ex_regwrite_i;
        tag_in.memread  = ex_memread_i;
    end

    assign hazard_o = ex_valid_i && tag_q[0].memread && (|hit0);
    assign bubble   = hazard_o || flush_i || !ex_valid_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tag_q <= '0;
        end else if (!stall_i) begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                tag_q[k] <= tag_q[k-1];
            end
            tag_q[0] <= bubble ? '0 : tag_in;
        end
    end

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        fwd_sel_mux #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .SEL_W  (SEL_W)
        ) u_mux (
            .tags_i       (tag_q),
            .src_addr_i   (FWD_RD_W'(src_addr_i[s*REG_AW +: REG_AW])),
            .rf_data_i    (src_data_i[s*DATA_W +: DATA_W]),
            .stage_data_i (stage_data_i),
            .operand_o    (operand_o[s*DATA_W +: DATA_W]),
            .sel_o        (fwd_sel_o[s*SEL_W +: SEL_W]),
            .hit0_o       (hit0[s])
        );
    end

`ifdef FWD_PERF_EN
    logic [31:0] fwd_inc;
    logic [32:0] fwd_sum;

    always_comb begin
        fwd_inc = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (fwd_sel_o[s*SEL_W +: SEL_W] != SEL_W'(FWD_SEL_RF))
                fwd_inc = fwd_inc + 32'd1;
        end
    end

    assign fwd_sum = {1'b0, fwd_cnt_o} + {1'b0, fwd_inc};

    // both counters saturate rather than wrap
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fwd_cnt_o    <= '0;
            hazard_cnt_o <= '0;
        end else begin
            if (ex_valid_i && !stall_i && !hazard_o)
                fwd_cnt_o <= fwd_sum[32] ? '1 : fwd_sum[31:0];
            if (hazard_o && !stall_i && (hazard_cnt_o != '1))
                hazard_cnt_o <= hazard_cnt_o + 32'd1;
        end
    end
`else
`endif

endmodule

// File: tb/tb_fwd_bypass_unit.sv
// tb_fwd_bypass_unit: directed and randomized checks of the bypass unit
// against a producer-list model kept in the bench.
module tb_fwd_bypass_unit;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NS = 2;
    localparam int D  = 2;
    localparam int SW = $clog2(D + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             stall;
    logic             flush;
    logic             ex_valid;
    logic [AW-1:0]    ex_rd;
    logic             ex_rw;
    logic             ex_mr;
    logic [NS*AW-1:0] src_addr;
    logic [NS*DW-1:0] src_data;
    logic [D*DW-1:0]  stage_data;
    logic [NS*DW-1:0] operand;
    logic [NS*SW-1:0] sel;
    logic             hazard;
`ifdef FWD_PERF_EN
    logic [31:0]      fwd_cnt;
    logic [31:0]      haz_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    typedef struct {
        bit v;
        int rd;
        bit rw;
        bit mr;
    } prod_t;

    prod_t  mt[D];
    longint m_fwd;
    longint m_haz;

    fwd_bypass_unit #(
        .DATA_W  (DW),
        .REG_AW  (AW),
        .NUM_SRC (NS),
        .DEPTH   (D)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .stall_i       (stall),
        .flush_i       (flush),
        .ex_valid_i    (ex_valid),
        .ex_rd_i       (ex_rd),
        .ex_regwrite_i (ex_rw),
        .ex_memread_i  (ex_mr),
        .src_addr_i    (src_addr),
        .src_data_i    (src_data),
        .stage_data_i  (stage_data),
        .operand_o     (operand),
        .fwd_sel_o     (sel),
`ifdef FWD_PERF_EN
        .fwd_cnt_o     (fwd_cnt),
        .hazard_cnt_o  (haz_cnt),
`endif
        .hazard_o      (hazard)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic int src_of(int s);
        return int'(src_addr[s*AW +: AW]);
    endfunction

    // youngest producer that writes the source register, 0 = regfile
    function automatic int exp_sel(int s);
        for (int k = 0; k < D; k++) begin
            if (mt[k].v && mt[k].rw && mt[k].rd != 0 &&
                mt[k].rd == src_of(s))
                return k + 1;
        end
        return 0;
    endfunction

    function automatic bit m_hazard();
        if (!ex_valid || !mt[0].v || !mt[0].mr) return 1'b0;
        for (int s = 0; s < NS; s++) begin
            if (exp_sel(s) == 1) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [31:0] exp_op(int s);
        int e;
        e = exp_sel(s);
        if (e == 0) return src_data[s*DW +: DW];
        return stage_data[(e-1)*DW +: DW];
    endfunction

    function automatic logic [31:0] sat(longint v);
        return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
    endfunction

    always @(posedge clk) begin
        bit hz;
        int nf;
        hz = m_hazard();
        if (rst) begin
            for (int k = 0; k < D; k++) mt[k] = '{0, 0, 0, 0};
            m_fwd = 0;
            m_haz = 0;
        end else if (!stall) begin
            nf = 0;
            for (int s = 0; s < NS; s++) if (exp_sel(s) != 0) nf++;
            if (ex_valid && !hz) m_fwd += nf;
            if (hz) m_haz += 1;
            for (int k = D - 1; k > 0; k--) mt[k] = mt[k-1];
            if (hz || flush || !ex_valid)
                mt[0] = '{0, 0, 0, 0};
            else
                mt[0] = '{1, int'(ex_rd), ex_rw, ex_mr};
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            bit hz;
            hz = m_hazard();
            chk("hazard", hazard, hz);
            for (int s = 0; s < NS; s++) begin
                chk($sformatf("sel%0d", s), sel[s*SW +: SW], exp_sel(s));
                if (!(hz && exp_sel(s) == 1))
                    chk($sformatf("op%0d", s), operand[s*DW +: DW], exp_op(s));
            end
`ifdef FWD_PERF_EN
            chk("fwd_cnt", fwd_cnt, sat(m_fwd));
            chk("haz_cnt", haz_cnt, sat(m_haz));
`endif
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input bit v, input int rd, input bit rw,
                          input bit mr);
        ex_valid = v;
        ex_rd    = AW'(rd);
        ex_rw    = rw;
        ex_mr    = mr;
    endtask

    task automatic set_src(input int a0, input int a1);
        src_addr = {AW'(a1), AW'(a0)};
    endtask

    task automatic set_stage(input logic [31:0] s0, input logic [31:0] s1);
        stage_data = {s1, s0};
    endtask

    initial begin
        rst   = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        set_ex(0, 0, 0, 0);
        set_src(3, 4);
        src_data = {32'h22, 32'h11};
        set_stage(0, 0);
        next();
        next();
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_sel", 32'(sel), 0);
        chk("rst_op0", operand[31:0], 32'h11);
        chk("rst_op1", operand[63:32], 32'h22);
        chk("rst_haz", hazard, 0);
        rst = 1'b0;

        // producers x5 then x5
        set_ex(1, 5, 1, 0);
        set_src(0, 0);
        next();
        set_ex(1, 5, 1, 0);
        set_src(5, 9);
        set_stage(32'h1234, 32'hBEEF);
        src_data = {32'h2222, 32'h1111};
        @(negedge clk);
        chk("t1_op0", operand[31:0], 32'h1234);
        chk("t1_sel0", 32'(sel[1:0]), 1);
        chk("t1_op1", operand[63:32], 32'h2222);
        chk("t1_haz", hazard, 0);
        next();

        set_ex(1, 0, 1, 0);
        set_src(0, 5);
        set_stage(32'hAAAA, 32'hBBBB);
        @(negedge clk);
        chk("t2_op1", operand[63:32], 32'hAAAA);
        chk("t2_sel1", 32'(sel[3:2]), 1);
        next();

        set_ex(1, 7, 1, 1);
        set_src(0, 5);
        src_data = {32'h5555, 32'h0};
        set_stage(32'hFFFF, 32'hBBBB);
        @(negedge clk);
        chk("t3_op0", operand[31:0], 32'h0);
        chk("t3_sel0", 32'(sel[1:0]), 0);
        chk("t3_sel1", 32'(sel[3:2]), 2);
        next();

        // load x7 now in tag0, consumer reads x7
        set_ex(1, 8, 1, 0);
        set_src(8, 7);
        set_stage(32'hC0DE, 32'h7777);
        @(negedge clk);
        chk("t4_haz", hazard, 1);
        next();
        @(negedge clk);
        chk("t4_haz_drop", hazard, 0);
        chk("t4_sel1", 32'(sel[3:2]), 2);
        chk("t4_op1", operand[63:32], 32'h7777);
        chk("t4_sel0", 32'(sel[1:0]), 0);
        next();

        set_ex(1, 9, 1, 0);
        set_src(0, 0);
        next();

        stall = 1'b1;
        set_ex(1, 10, 1, 0);
        set_src(9, 8);
        set_stage(32'h9999, 32'h8888);
        repeat (3) begin
            @(negedge clk);
            chk("st_sel0", 32'(sel[1:0]), 1);
            chk("st_sel1", 32'(sel[3:2]), 2);
            chk("st_op0", operand[31:0], 32'h9999);
            chk("st_op1", operand[63:32], 32'h8888);
            next();
        end
        stall = 1'b0;
        @(negedge clk);
        chk("rel_sel0", 32'(sel[1:0]), 1);
        next();
        @(negedge clk);
        chk("sh_sel0", 32'(sel[1:0]), 2);
        chk("sh_sel1", 32'(sel[3:2]), 0);
        chk("sh_op0", operand[31:0], 32'h8888);

        flush = 1'b1;
        set_ex(1, 11, 1, 0);
        next();
        flush = 1'b0;
        set_ex(1, 12, 1, 0);
        set_src(11, 10);
        @(negedge clk);
        chk("fl_sel0", 32'(sel[1:0]), 0);
        chk("fl_sel1", 32'(sel[3:2]), 2);

        rst = 1'b1;
        next();
        rst = 1'b0;
        set_src(10, 12);
        @(negedge clk);
        chk("rs_sel", 32'(sel), 0);
        chk("rs_haz", hazard, 0);
`ifdef FWD_PERF_EN
        chk("rs_fwd_cnt", fwd_cnt, 0);
        chk("rs_haz_cnt", haz_cnt, 0);
`endif
        next();

        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 99) < 2);
            stall    = ($urandom_range(0, 99) < 12);
            flush    = ($urandom_range(0, 99) < 10);
            set_ex($urandom_range(0, 99) < 85, $urandom_range(0, 7),
                   $urandom_range(0, 99) < 80, $urandom_range(0, 99) < 30);
            set_src($urandom_range(0, 7), $urandom_range(0, 7));
            src_data   = {$urandom(), $urandom()};
            stage_data = {$urandom(), $urandom()};
            next();
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
